// File: rtl/cam_lru_scoreboard.sv
// cam_lru_scoreboard
//   Reference scoreboard for the CAM grader. It keeps an LRU key/value model
//   of DEPTH entries and takes one monitored transaction per handshake. Each
//   READ is checked against the model. Errors are counted and the first one
//   is captured. Per-entry hit/evict coverage and back-to-back write/write
//   and write/read coverage are accumulated.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   tr_valid / tr_ready   transaction handshake; ready only in IDLE
//   tr_type               0=RESET 1=WRITE 2=READ 3=illegal
//   tr_key, tr_wdata      key and write data
//   tr_rdata, tr_valid_o  DUT read response being checked
//   tr_ltime              DUT logical timestamp
//   err_pulse             one-cycle pulse per read error
//   err_count             saturating error count
//   first_err_*           sticky capture of the first error
//   cov_hits/cov_evicts   sticky per-entry hit / LRU-evict coverage
//   cov_ww/cov_wr         sticky back-to-back WRITE->WRITE / WRITE->READ
//
// state | meaning
// IDLE  | ready; a valid transaction is latched into l_*
// EXEC  | evaluate the latched transaction, commit on the closing edge
module cam_lru_scoreboard #(
  parameter int KEY_W  = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tr_valid,
  output logic              tr_ready,
  input  logic [1:0]        tr_type,
  input  logic [KEY_W-1:0]  tr_key,
  input  logic [DATA_W-1:0] tr_wdata,
  input  logic [DATA_W-1:0] tr_rdata,
  input  logic              tr_valid_o,
  input  logic [31:0]       tr_ltime,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [KEY_W-1:0]  first_err_key,
  output logic [31:0]       first_err_ltime,
  output logic [DEPTH-1:0]  cov_hits,
  output logic [DEPTH-1:0]  cov_evicts,
  output logic              cov_ww,
  output logic              cov_wr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] AGE_MAX = AW'(DEPTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [1:0] T_RESET = 2'd0;
  localparam logic [1:0] T_WRITE = 2'd1;
  localparam logic [1:0] T_READ  = 2'd2;

  logic [0:0]        state;

  logic [1:0]        l_type;
  logic [KEY_W-1:0]  l_key;
  logic [DATA_W-1:0] l_wdata;
  logic [DATA_W-1:0] l_rdata;
  logic              l_valid_o;
  logic [31:0]       l_ltime;

  logic [DEPTH-1:0]  ent_valid;
  logic [KEY_W-1:0]  ent_key [DEPTH];
  logic [DATA_W-1:0] ent_val [DEPTH];
  logic [AW-1:0]     ent_age [DEPTH];

  logic              h_valid;
  logic [1:0]        h_type;
  logic [KEY_W-1:0]  h_key;
  logic [DATA_W-1:0] h_wdata;
  logic [31:0]       h_ltime;

  assign tr_ready = (state == S_IDLE);

  // Lookup: descending scan so the lowest matching / free index wins.
  logic          hit, free;
  logic [AW-1:0] hit_idx, free_idx, vic_idx;

  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    vic_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid[i] && (ent_key[i] == l_key)) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
      if (!ent_valid[i]) begin
        free     = 1'b1;
        free_idx = AW'(i);
      end
      // Only consulted when every entry is valid, so stale ages never matter.
      if (ent_age[i] == AGE_MAX) vic_idx = AW'(i);
    end
  end

  // Next model contents for the latched transaction.
  logic [DEPTH-1:0]  nxt_valid;
  logic [KEY_W-1:0]  nxt_key [DEPTH];
  logic [DATA_W-1:0] nxt_val [DEPTH];
  logic [AW-1:0]     nxt_age [DEPTH];
  logic              touch_en, ins_en, do_err;
  logic [AW-1:0]     sel_idx;
  logic [DEPTH-1:0]  hit_set, evict_set;

  always_comb begin
    nxt_valid = ent_valid;
    nxt_key   = ent_key;
    nxt_val   = ent_val;
    nxt_age   = ent_age;
    touch_en  = 1'b0;
    ins_en    = 1'b0;
    do_err    = 1'b0;
    sel_idx   = '0;
    hit_set   = '0;
    evict_set = '0;
    case (l_type)
      T_RESET: nxt_valid = '0;
      T_WRITE: begin
        if (hit) begin
          touch_en         = 1'b1;
          sel_idx          = hit_idx;
          nxt_val[hit_idx] = l_wdata;
        end else if (free) begin
          ins_en  = 1'b1;
          sel_idx = free_idx;
        end else begin
          touch_en           = 1'b1;
          sel_idx            = vic_idx;
          nxt_key[vic_idx]   = l_key;
          nxt_val[vic_idx]   = l_wdata;
          evict_set[vic_idx] = 1'b1;
        end
      end
      T_READ: begin
        if (hit) begin
          touch_en         = 1'b1;
          sel_idx          = hit_idx;
          hit_set[hit_idx] = 1'b1;
          do_err           = !l_valid_o || (l_rdata != ent_val[hit_idx]);
        end else begin
          do_err = l_valid_o;
        end
      end
      default: ;
    endcase

    // Touch: entries younger than the touched one age by one.
    // Insert: every valid entry ages by one; the new entry is youngest.
    for (int i = 0; i < DEPTH; i++) begin
      if (touch_en && ent_valid[i] && (ent_age[i] < ent_age[sel_idx]))
        nxt_age[i] = ent_age[i] + 1'b1;
      if (ins_en && ent_valid[i])
        nxt_age[i] = ent_age[i] + 1'b1;
    end
    if (touch_en) nxt_age[sel_idx] = '0;
    if (ins_en) begin
      nxt_valid[sel_idx] = 1'b1;
      nxt_key[sel_idx]   = l_key;
      nxt_val[sel_idx]   = l_wdata;
      nxt_age[sel_idx]   = '0;
    end
  end

  // ltime + 1 wraps naturally in 32 bits, so 0xFFFFFFFF -> 0 qualifies.
  logic b2b, ww_evt, wr_evt;
  assign b2b    = h_valid && (h_type == T_WRITE) && (l_ltime == h_ltime + 32'd1);
  assign ww_evt = b2b && (l_type == T_WRITE) && (l_key == h_key) && (l_wdata != h_wdata);
  assign wr_evt = b2b && (l_type == T_READ) && (l_key == h_key);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      l_type          <= '0;
      l_key           <= '0;
      l_wdata         <= '0;
      l_rdata         <= '0;
      l_valid_o       <= 1'b0;
      l_ltime         <= '0;
      ent_valid       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_key[i] <= '0;
        ent_val[i] <= '0;
        ent_age[i] <= '0;
      end
      h_valid         <= 1'b0;
      h_type          <= '0;
      h_key           <= '0;
      h_wdata         <= '0;
      h_ltime         <= '0;
      err_pulse       <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_key   <= '0;
      first_err_ltime <= '0;
      cov_hits        <= '0;
      cov_evicts      <= '0;
      cov_ww          <= 1'b0;
      cov_wr          <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tr_valid) begin
            l_type    <= tr_type;
            l_key     <= tr_key;
            l_wdata   <= tr_wdata;
            l_rdata   <= tr_rdata;
            l_valid_o <= tr_valid_o;
            l_ltime   <= tr_ltime;
            state     <= S_EXEC;
          end
        end
        default: begin
          ent_valid <= nxt_valid;
          ent_key   <= nxt_key;
          ent_val   <= nxt_val;
          ent_age   <= nxt_age;
          h_valid   <= 1'b1;
          h_type    <= l_type;
          h_key     <= l_key;
          h_wdata   <= l_wdata;
          h_ltime   <= l_ltime;
          cov_hits   <= cov_hits | hit_set;
          cov_evicts <= cov_evicts | evict_set;
          if (ww_evt) cov_ww <= 1'b1;
          if (wr_evt) cov_wr <= 1'b1;
          if (do_err) begin
            err_pulse <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_key   <= l_key;
              first_err_ltime <= l_ltime;
            end
          end
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_lru_scoreboard.sv
module tb_cam_lru_scoreboard;
  localparam int KW  = 16;
  localparam int DW  = 16;
  localparam int DEP = 4;
  localparam int EW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tr_valid = 1'b0;
  logic          tr_ready;
  logic [1:0]    tr_type = '0;
  logic [KW-1:0] tr_key = '0;
  logic [DW-1:0] tr_wdata = '0;
  logic [DW-1:0] tr_rdata = '0;
  logic          tr_valid_o = 1'b0;
  logic [31:0]   tr_ltime = '0;
  logic          err_pulse;
  logic [EW-1:0] err_count;
  logic          first_err_valid;
  logic [KW-1:0] first_err_key;
  logic [31:0]   first_err_ltime;
  logic [DEP-1:0] cov_hits, cov_evicts;
  logic          cov_ww, cov_wr;

  cam_lru_scoreboard #(.KEY_W(KW), .DATA_W(DW), .DEPTH(DEP), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_type(tr_type), .tr_key(tr_key), .tr_wdata(tr_wdata), .tr_rdata(tr_rdata),
    .tr_valid_o(tr_valid_o), .tr_ltime(tr_ltime), .err_pulse(err_pulse),
    .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_key(first_err_key), .first_err_ltime(first_err_ltime),
    .cov_hits(cov_hits), .cov_evicts(cov_evicts), .cov_ww(cov_ww), .cov_wr(cov_wr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]    t;
    logic [KW-1:0] k;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          vo;
    logic [31:0]   lt;
  } row_t;

  typedef struct {
    logic           err;
    logic [EW-1:0]  cnt;
    logic           fev;
    logic [KW-1:0]  fkey;
    logic [31:0]    flt;
    logic [DEP-1:0] hits;
    logic [DEP-1:0] evs;
    logic           ww;
    logic           wr;
  } exp_t;

  exp_t sbq[$];

  // Reference model: slots plus a recency list of slot numbers, MRU first.
  logic           m_used [DEP];
  logic [KW-1:0]  m_key  [DEP];
  logic [DW-1:0]  m_val  [DEP];
  int             rq[$];
  logic [EW-1:0]  m_cnt;
  logic           m_fev;
  logic [KW-1:0]  m_fkey;
  logic [31:0]    m_flt;
  logic [DEP-1:0] m_hits, m_evs;
  logic           m_ww, m_wr;
  logic           hv;
  logic [1:0]     ht;
  logic [KW-1:0]  hk;
  logic [DW-1:0]  hw;
  logic [31:0]    hl;

  function automatic row_t mk(input logic [1:0] t, input logic [KW-1:0] k,
                              input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                              input logic vo, input logic [31:0] lt);
    row_t r;
    r.t = t; r.k = k; r.wd = wd; r.rd = rd; r.vo = vo; r.lt = lt;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) begin
      m_used[i] = 1'b0; m_key[i] = '0; m_val[i] = '0;
    end
    rq.delete();
    m_cnt = '0; m_fev = 1'b0; m_fkey = '0; m_flt = '0;
    m_hits = '0; m_evs = '0; m_ww = 1'b0; m_wr = 1'b0;
    hv = 1'b0; ht = '0; hk = '0; hw = '0; hl = '0;
  endtask

  task automatic bump(input int s);
    for (int i = 0; i < rq.size(); i++)
      if (rq[i] == s) begin
        rq.delete(i);
        break;
      end
    rq.push_front(s);
  endtask

  task automatic model_step(input row_t r);
    int   s;
    logic err;
    exp_t e;
    err = 1'b0;
    s = -1;
    for (int i = 0; i < DEP; i++)
      if (m_used[i] && m_key[i] == r.k) s = i;
    case (r.t)
      2'd0: begin
        for (int i = 0; i < DEP; i++) m_used[i] = 1'b0;
        rq.delete();
      end
      2'd1: begin
        if (s >= 0) begin
          m_val[s] = r.wd;
          bump(s);
        end else begin
          for (int i = DEP - 1; i >= 0; i--) if (!m_used[i]) s = i;
          if (s < 0) begin
            s = rq[rq.size() - 1];
            m_evs[s] = 1'b1;
          end
          m_used[s] = 1'b1; m_key[s] = r.k; m_val[s] = r.wd;
          bump(s);
        end
      end
      2'd2: begin
        if (s >= 0) begin
          m_hits[s] = 1'b1;
          err = !r.vo || (r.rd != m_val[s]);
          bump(s);
        end else begin
          err = r.vo;
        end
      end
      default: ;
    endcase
    if (hv && ht == 2'd1 && r.lt == hl + 32'd1) begin
      if (r.t == 2'd1 && r.k == hk && r.wd != hw) m_ww = 1'b1;
      if (r.t == 2'd2 && r.k == hk) m_wr = 1'b1;
    end
    hv = 1'b1; ht = r.t; hk = r.k; hw = r.wd; hl = r.lt;
    if (err) begin
      if (m_cnt != {EW{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (!m_fev) begin
        m_fev = 1'b1; m_fkey = r.k; m_flt = r.lt;
      end
    end
    e.err = err; e.cnt = m_cnt; e.fev = m_fev; e.fkey = m_fkey; e.flt = m_flt;
    e.hits = m_hits; e.evs = m_evs; e.ww = m_ww; e.wr = m_wr;
    sbq.push_back(e);
  endtask

  task automatic drive(input row_t r);
    tr_type = r.t; tr_key = r.k; tr_wdata = r.wd;
    tr_rdata = r.rd; tr_valid_o = r.vo; tr_ltime = r.lt;
  endtask

  // Called on a negedge; returns on the negedge where the result is visible.
  task automatic send(input row_t r);
    int n;
    model_step(r);
    drive(r);
    tr_valid = 1'b1;
    n = 0;
    while (!tr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tr_ready got=0 want=1");
    end
    @(negedge clk);
    tr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (tr_ready !== 1'b1 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got ready=%0b pulse=%0b want ready=1 pulse=0", tr_ready, err_pulse);
    end
    checks++;
    if (err_count !== '0 || first_err_valid !== 1'b0 || first_err_key !== '0 || first_err_ltime !== '0) begin
      errors++;
      $display("FAIL reset_err got cnt=%0d fev=%0b fkey=%h flt=%h want all 0",
               err_count, first_err_valid, first_err_key, first_err_ltime);
    end
    checks++;
    if ({cov_hits, cov_evicts, cov_ww, cov_wr} !== '0) begin
      errors++;
      $display("FAIL reset_cov got hits=%b ev=%b ww=%b wr=%b want all 0", cov_hits, cov_evicts, cov_ww, cov_wr);
    end
  endtask

  task automatic run_rows(input string nm, input row_t rows[$]);
    exp_t e;
    foreach (rows[i]) begin
      send(rows[i]);
      e = sbq.pop_front();
      checks++;
      if (err_pulse !== e.err || err_count !== e.cnt) begin
        errors++;
        $display("FAIL %s[%0d] got pulse=%0b cnt=%0d want pulse=%0b cnt=%0d",
                 nm, i, err_pulse, err_count, e.err, e.cnt);
      end
      checks++;
      if ({first_err_valid, first_err_key, first_err_ltime} !== {e.fev, e.fkey, e.flt}) begin
        errors++;
        $display("FAIL %s[%0d]_first got v=%0b k=%h t=%h want v=%0b k=%h t=%h", nm, i,
                 first_err_valid, first_err_key, first_err_ltime, e.fev, e.fkey, e.flt);
      end
      checks++;
      if ({cov_hits, cov_evicts, cov_ww, cov_wr} !== {e.hits, e.evs, e.ww, e.wr}) begin
        errors++;
        $display("FAIL %s[%0d]_cov got hits=%b ev=%b ww=%b wr=%b want hits=%b ev=%b ww=%b wr=%b",
                 nm, i, cov_hits, cov_evicts, cov_ww, cov_wr, e.hits, e.evs, e.ww, e.wr);
      end
    end
  endtask

  task automatic test_lru();
    row_t rows[$];
    rows.push_back(mk(2'd1, 16'd1, 16'h0011, 16'h0, 1'b0, 32'd100));
    rows.push_back(mk(2'd1, 16'd2, 16'h0022, 16'h0, 1'b0, 32'd116));
    rows.push_back(mk(2'd1, 16'd3, 16'h0033, 16'h0, 1'b0, 32'd132));
    rows.push_back(mk(2'd1, 16'd4, 16'h0044, 16'h0, 1'b0, 32'd148));
    rows.push_back(mk(2'd2, 16'd2, 16'h0, 16'h0022, 1'b1, 32'd164));
    rows.push_back(mk(2'd1, 16'd5, 16'h0055, 16'h0, 1'b0, 32'd180));
    rows.push_back(mk(2'd2, 16'd1, 16'h0, 16'h0, 1'b0, 32'd196));
    rows.push_back(mk(2'd2, 16'd1, 16'h0, 16'h0011, 1'b1, 32'd212));
    rows.push_back(mk(2'd2, 16'd3, 16'h0, 16'hFFFF, 1'b1, 32'd228));
    run_rows("lru", rows);
    checks++;
    if (cov_evicts[0] !== 1'b1 || cov_hits[1] !== 1'b1 || err_count !== 3'd2 || first_err_key !== 16'd1) begin
      errors++;
      $display("FAIL lru_plan got ev0=%b hit1=%b cnt=%0d fkey=%0d want 1 1 2 1",
               cov_evicts[0], cov_hits[1], err_count, first_err_key);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    rows.push_back(mk(2'd1, 16'd7, 16'd1, 16'h0, 1'b0, 32'd9));
    rows.push_back(mk(2'd1, 16'd7, 16'd2, 16'h0, 1'b0, 32'd10));
    rows.push_back(mk(2'd2, 16'd7, 16'h0, 16'd2, 1'b1, 32'd12));
    rows.push_back(mk(2'd1, 16'd8, 16'd8, 16'h0, 1'b0, 32'hFFFF_FFFF));
    rows.push_back(mk(2'd2, 16'd8, 16'h0, 16'd8, 1'b1, 32'd0));
    rows.push_back(mk(2'd3, 16'd8, 16'h0, 16'h0, 1'b1, 32'd1));
    run_rows("b2b", rows);
    checks++;
    if (cov_ww !== 1'b1 || cov_wr !== 1'b1) begin
      errors++;
      $display("FAIL b2b_plan got ww=%b wr=%b want 1 1", cov_ww, cov_wr);
    end
  endtask

  task automatic test_reset_txn();
    row_t rows[$];
    rows.push_back(mk(2'd0, 16'd0, 16'h0, 16'h0, 1'b0, 32'd300));
    rows.push_back(mk(2'd2, 16'd5, 16'h0, 16'h0055, 1'b1, 32'd320));
    run_rows("rst_txn", rows);
  endtask

  task automatic test_hold_valid();
    row_t a, b;
    exp_t e;
    int   acc;
    a = mk(2'd1, 16'h40, 16'h4040, 16'h0, 1'b0, 32'd400);
    b = mk(2'd2, 16'h99, 16'h0, 16'h0, 1'b1, 32'd420);
    model_step(a);
    drive(a);
    tr_valid = 1'b1;
    @(negedge clk);
    model_step(b);
    drive(b);
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      if (tr_ready) acc++;
      @(negedge clk);
    end
    tr_valid = 1'b0;
    void'(sbq.pop_front());
    e = sbq.pop_front();
    checks++;
    if (acc != 1) begin
      errors++;
      $display("FAIL hold_accepts got=%0d want=1", acc);
    end
    checks++;
    if (err_pulse !== e.err || err_count !== e.cnt) begin
      errors++;
      $display("FAIL hold_err got pulse=%0b cnt=%0d want pulse=%0b cnt=%0d", err_pulse, err_count, e.err, e.cnt);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (err_pulse !== 1'b0 || err_count !== e.cnt || tr_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_quiet got pulse=%0b cnt=%0d ready=%0b want 0 %0d 1", err_pulse, err_count, tr_ready, e.cnt);
    end
  endtask

  task automatic test_reset_mid_exec();
    row_t rows[$];
    drive(mk(2'd1, 16'h77, 16'h7777, 16'h0, 1'b0, 32'd500));
    tr_valid = 1'b1;
    @(negedge clk);
    tr_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (tr_ready !== 1'b1 || err_pulse !== 1'b0 || err_count !== '0 || first_err_valid !== 1'b0 ||
        {cov_hits, cov_evicts, cov_ww, cov_wr} !== '0) begin
      errors++;
      $display("FAIL rst_exec_outputs got ready=%0b pulse=%0b cnt=%0d fev=%0b hits=%b ev=%b ww=%b wr=%b want reset",
               tr_ready, err_pulse, err_count, first_err_valid, cov_hits, cov_evicts, cov_ww, cov_wr);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rows.push_back(mk(2'd2, 16'h77, 16'h0, 16'h7777, 1'b0, 32'd520));
    rows.push_back(mk(2'd2, 16'h77, 16'h0, 16'h7777, 1'b1, 32'd540));
    run_rows("rst_exec", rows);
  endtask

  task automatic test_saturate();
    row_t rows[$];
    for (int i = 0; i < 8; i++)
      rows.push_back(mk(2'd2, 16'h55, 16'h0, 16'h0, 1'b1, 32'd1000 + 32'(i * 16)));
    run_rows("sat", rows);
    checks++;
    if (err_count !== 3'd7) begin
      errors++;
      $display("FAIL sat_final got=%0d want=7", err_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_lru();
    test_back_to_back();
    test_reset_txn();
    test_hold_valid();
    test_reset_mid_exec();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
